// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: control FSM plus the A/Q/Q-1/M register datapath.
// One start/done handshake per signed WIDTH x WIDTH product; op_sel/shift_en drive the mux stages.
module booth_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           op_sel,
   output logic                 shift_en
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_ADD  = 2'b01;
   localparam logic [1:0] SEL_SUB  = 2'b10;

   state_t           state, next_state;
   logic [WIDTH:0]   a;        // accumulator with guard bit
   logic [WIDTH:0]   m;        // multiplicand sign-extended to match a
   logic [WIDTH-1:0] q;
   logic             qm1;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   a_next;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_state = IDLE;
      busy       = 1'b0;
      done       = 1'b0;
      op_sel     = SEL_HOLD;
      shift_en   = 1'b0;
      case (state)
         IDLE:  next_state = start ? LOAD : IDLE;
         LOAD: begin
            busy       = 1'b1;
            next_state = EVAL;
         end
         EVAL: begin
            busy       = 1'b1;
            next_state = SHIFT;
            case ({q[0], qm1})
               2'b01:   op_sel = SEL_ADD;
               2'b10:   op_sel = SEL_SUB;
               default: op_sel = SEL_HOLD;
            endcase
         end
         SHIFT: begin
            busy       = 1'b1;
            shift_en   = 1'b1;
            // count reaching 0 after this shift ends the run; <=1 also guards underflow
            next_state = (count <= CW'(1)) ? DONE : EVAL;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      a_next = a;
      if (op_sel == SEL_ADD)      a_next = a + m;
      else if (op_sel == SEL_SUB) a_next = a - m;
   end

   // NOTE: all datapath registers are reset so an aborted run never leaves a
   // partial product visible after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a       <= '0;
         m       <= '0;
         q       <= '0;
         qm1     <= 1'b0;
         count   <= '0;
         product <= '0;
      end else begin
         case (state)
            LOAD: begin
               a     <= '0;
               q     <= multiplier;
               qm1   <= 1'b0;
               m     <= {multiplicand[WIDTH-1], multiplicand};
               count <= CW'(WIDTH);
            end
            EVAL: a <= a_next;
            SHIFT: begin
               {a, q, qm1} <= {a[WIDTH], a, q};
               if (count != '0) count <= count - CW'(1);
               // capture the post-shift {A[WIDTH-1:0],Q} so product and done rise together
               if (count <= CW'(1)) product <= {a, q[WIDTH-1:1]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (WIDTH=8): directed vector table, multi-cycle
// handshake/reset sequences and a randomized sweep against a signed-arithmetic reference.
module tb_booth_seq_ctrl;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;
   logic [1:0]     op_sel;
   logic           shift_en;

   int checks = 0;
   int errors = 0;

   booth_seq_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .op_sel       (op_sel),
      .shift_en     (shift_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   m;
      logic [W-1:0]   q;
      logic [2*W-1:0] p;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: signed product by plain integer arithmetic.
   function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] m, input logic [W-1:0] q);
      int prod;
      prod = int'($signed(m)) * int'($signed(q));
      return prod[2*W-1:0];
   endfunction

   // Reference: Booth recoding of multiplier bit pair i -> expected mux select.
   function automatic logic [1:0] ref_sel(input logic [W-1:0] q, input int i);
      logic cur, prev;
      cur  = q[i];
      prev = (i == 0) ? 1'b0 : q[i-1];
      if (cur == 1'b0 && prev == 1'b1) return 2'b01;
      if (cur == 1'b1 && prev == 1'b0) return 2'b10;
      return 2'b00;
   endfunction

   // One full operation. Cycle k = the interval after clock edge k, edge 0 sampling start.
   // poke=1 adds ignored start pulses during SHIFT (edge 5) and DONE (edge 18).
   task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] exp_p, input bit poke);
      @(negedge clk);
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      for (int k = 0; k <= 17; k++) begin
         @(negedge clk);
         if (k == 0) start = 1'b0;
         // operands only need to hold through the edge leaving LOAD
         if (k == 2) begin
            multiplicand = W'($urandom);
            multiplier   = W'($urandom);
         end
         check("busy", busy, (k < 17));
         check("done", done, (k == 17));
         check("shift_en", shift_en, (k >= 2 && k % 2 == 0 && k < 17));
         check("op_sel", op_sel, (k % 2 == 1 && k < 17) ? ref_sel(q, (k - 1) / 2) : 2'b00);
         if (k == 17) check("product", product, exp_p);
         if (poke && k == 4) start = 1'b1;
         if (poke && k == 5) start = 1'b0;
         if (poke && k == 17) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      @(negedge clk);
      check("no_queue_busy", busy, 1'b0);
      check("product_held", product, exp_p);
   endtask

   vec_t vecs[$];
   int   no_done_bad;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;

      vecs.push_back('{8'h07, 8'hFD, 16'hFFEB});  // 7 * -3
      vecs.push_back('{8'h80, 8'h80, 16'h4000});  // -128 * -128
      vecs.push_back('{8'h7F, 8'h80, 16'hC080});  // 127 * -128
      vecs.push_back('{8'h55, 8'h00, 16'h0000});  // multiplier zero
      vecs.push_back('{8'h01, 8'h01, 16'h0001});
      vecs.push_back('{8'hFF, 8'hFF, 16'h0001});  // -1 * -1
      vecs.push_back('{8'h7F, 8'h7F, 16'h3F01});  // 127 * 127
      vecs.push_back('{8'h80, 8'h01, 16'hFF80});  // -128 * 1
      vecs.push_back('{8'hFF, 8'h7F, 16'hFF81});  // -1 * 127
      vecs.push_back('{8'h00, 8'h80, 16'h0000});
      vecs.push_back('{8'hFB, 8'h06, 16'hFFE2});  // -5 * 6

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_product", product, 16'h0000);
      check("rst_op_sel", op_sel, 2'b00);
      check("rst_shift_en", shift_en, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_op(vecs[i].m, vecs[i].q, vecs[i].p, 1'b0);

      // Start pulses during a run and during DONE are dropped; a fresh start afterwards works.
      run_op(8'h07, 8'hFD, 16'hFFEB, 1'b1);
      run_op(8'h80, 8'h80, 16'h4000, 1'b0);

      // Asynchronous reset mid-run: outputs clear at once, no done follows.
      @(negedge clk);
      multiplicand = 8'h7F;
      multiplier   = 8'h7F;
      start        = 1'b1;
      repeat (9) @(negedge clk);
      start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_product", product, 16'h0000);
      check("abort_op_sel", op_sel, 2'b00);
      check("abort_shift_en", shift_en, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      no_done_bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done || busy) no_done_bad++;
      end
      check("abort_quiet", no_done_bad, 0);
      run_op(8'hFB, 8'h06, 16'hFFE2, 1'b0);

      // Randomized sweep against the arithmetic reference.
      for (int n = 0; n < 250; n++) begin
         logic [W-1:0] rm, rq;
         rm = W'($urandom);
         rq = W'($urandom_range(0, 255));
         run_op(rm, rq, ref_product(rm, rq), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
